// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a; the strobe polarity constant matches the control decoder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Memory strobes from the control decoder are asserted low.
    localparam logic ACTIVE_LOW_ASSERT = 1'b0;

    localparam int DEF_DEPTH_LOG2  = 8;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, clearable read port.
// Latency: one clock from we/re/clr to array update or rdata.
// Backpressure: none; the caller pulses we/re/clr for exactly one cycle per access.
//
// Ports: clk, rst (sync, clears rdata only); we/re/clr strobes; index (word);
//        wdata in; rdata out (holds between reads).
module dmem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    // clr zeroes the read register for rejected accesses; otherwise it only
    // changes on a read, so writes leave the last load value visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decodes active-low strobes, inserts WAIT_CYCLES wait states, stalls the core.
// Latency: request seen in cycle 0, ready (and err for bad address) in cycle WAIT_CYCLES+1.
// Backpressure: stall is high from the request cycle through the last wait cycle; one access at a time.
//
// Ports: clk, rst (sync, active-high); mem_enable/mem_read/mem_write (active-low);
//        addr (byte address), wdata; rdata (registered), ready, stall, err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enable,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              err
);

    // The counter only ever holds WAIT_CYCLES-1 down to 0.
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               wr_q;

    logic               req;
    logic               malformed;
    logic               go_resp;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic               acc_wr;
    logic               acc_bad;
    logic               bad_q;
    logic               arr_we;
    logic               arr_re;
    logic               arr_clr;

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != '0);
    endfunction

    assign req       = (mem_enable == ACTIVE_LOW_ASSERT) && (mem_read != mem_write);
    assign malformed = (mem_enable == ACTIVE_LOW_ASSERT) && (mem_read == mem_write);

    // With zero wait states the array is accessed on the same edge the request
    // is latched, so the live inputs must feed the array from IDLE.
    assign acc_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign acc_wr    = (state_q == IDLE) ? (mem_write == ACTIVE_LOW_ASSERT) : wr_q;
    assign acc_bad   = addr_bad(acc_addr);
    assign bad_q     = addr_bad(addr_q);

    // rst blocks a write whose commit edge coincides with it.
    assign arr_we  = go_resp && acc_wr && !acc_bad && !rst;
    assign arr_re  = go_resp && !acc_wr && !acc_bad;
    assign arr_clr = go_resp && acc_bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        stall   = 1'b0;
        ready   = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req;
                err   = malformed;
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                ready   = 1'b1;
                err     = bad_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs read as their reset values while rst is held.
        if (rst) begin
            stall = 1'b0;
            ready = 1'b0;
            err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wr_q    <= (mem_write == ACTIVE_LOW_ASSERT);
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .clr   (arr_clr),
        .index (acc_addr[DEPTH_LOG2+1:2]),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder (WAIT_CYCLES=2) plus a directed check of a zero-wait build.
// Latency: expected responses are stamped with the cycle they must appear in.
// Backpressure: the driver honours stall by holding one access in flight at a time.
module tb_dmem_responder;

    localparam int WC    = 2;
    localparam int DL    = 8;
    localparam int LIMIT = 4 << DL;   // first byte address past the array

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enable, mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        ready, stall, err;

    logic        en0, rd0, wr0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, stall0, err0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC), .DATA_W(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .wdata(wdata), .rdata(rdata),
        .ready(ready), .stall(stall), .err(err)
    );

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0), .DATA_W(32), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .mem_enable(en0), .mem_read(rd0),
        .mem_write(wr0), .addr(addr0), .wdata(wdata0), .rdata(rdata0),
        .ready(ready0), .stall(stall0), .err(err0)
    );

    typedef struct {
        int          cyc;
        logic        rdy;
        logic        er;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rdata;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic [31:0] pool [8] = '{32'h000, 32'h004, 32'h010, 32'h020,
                              32'h080, 32'h100, 32'h200, 32'h3FC};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ready || err)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got ready=%0b err=%0b want no response (cycle %0d)",
                         ready, err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                check("resp_ready", 64'(ready), 64'(e.rdy));
                check("resp_err", 64'(err), 64'(e.er));
                check("resp_rdata", 64'(rdata), 64'(e.data));
            end
        end
    end

    function automatic logic is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= LIMIT);
    endfunction

    task automatic drive_junk();
        mem_enable = 1'($urandom_range(0, 1));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        addr       = $urandom;
        wdata      = $urandom;
    endtask

    task automatic drive_idle();
        drive_junk();
        mem_enable = 1'b1;
    endtask

    // One complete access on the main DUT; the model decides the response.
    task automatic access(input logic is_wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk); #1;
        mem_enable = 1'b0;
        mem_read   = is_wr;
        mem_write  = !is_wr;
        addr       = a;
        wdata      = d;
        e.cyc = cyc + WC + 1;
        e.rdy = 1'b1;
        e.er  = 1'b0;
        if (is_bad(a)) begin
            e.er       = 1'b1;
            last_rdata = '0;
        end else if (is_wr) begin
            ref_mem[int'(a / 4)] = d;
        end else begin
            last_rdata = ref_mem.exists(int'(a / 4)) ? ref_mem[int'(a / 4)] : 32'h0;
        end
        e.data = last_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        check("stall_req", 64'(stall), 64'd1);
        for (int i = 0; i < WC; i++) begin
            @(posedge clk); #1;
            drive_junk();
            @(negedge clk);
            check("stall_wait", 64'(stall), 64'd1);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("stall_resp", 64'(stall), 64'd0);
    endtask

    task automatic malformed_req();
        exp_t e;
        @(posedge clk); #1;
        mem_enable = 1'b0;
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = mem_read;
        addr       = pool[$urandom_range(0, 7)];
        wdata      = $urandom;
        e.cyc  = cyc;
        e.rdy  = 1'b0;
        e.er   = 1'b1;
        e.data = last_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        check("stall_malformed", 64'(stall), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            check("stall_idle", 64'(stall), 64'd0);
        end
    endtask

    task automatic access0(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] want_data, input logic want_err);
        @(posedge clk); #1;
        en0 = 1'b0; rd0 = is_wr; wr0 = !is_wr; addr0 = a; wdata0 = d;
        @(negedge clk);
        check("w0_stall_c0", 64'(stall0), 64'd1);
        check("w0_ready_c0", 64'(ready0), 64'd0);
        @(posedge clk); #1;
        en0 = 1'b1;
        @(negedge clk);
        check("w0_ready_c1", 64'(ready0), 64'd1);
        check("w0_stall_c1", 64'(stall0), 64'd0);
        check("w0_err_c1", 64'(err0), 64'(want_err));
        check("w0_rdata_c1", 64'(rdata0), 64'(want_data));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] keep;
        int          kind;

        rst = 1'b1;
        drive_idle();
        en0 = 1'b1; rd0 = 1'b1; wr0 = 1'b1; addr0 = '0; wdata0 = '0;
        last_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store then load.
        access(1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0);
        // Misaligned store must not land; the following load proves it.
        access(1'b1, 32'h13, 32'hFFFFFFFF);
        access(1'b0, 32'h10, 32'h0);
        malformed_req();
        access(1'b0, 32'h10, 32'h0);

        foreach (pool[i]) access(1'b1, pool[i], $urandom);

        // Write aborted by reset on its commit edge.
        keep = ref_mem[int'(32'h20 / 4)];
        @(posedge clk); #1;
        mem_enable = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        addr = 32'h20; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        check("abort_stall_c0", 64'(stall), 64'd1);
        @(posedge clk); #1;
        drive_junk();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        check("abort_rdata", 64'(rdata), 64'd0);
        check("abort_ready", 64'(ready), 64'd0);
        check("abort_stall", 64'(stall), 64'd0);
        access(1'b0, 32'h20, 32'h0);
        check("abort_not_written", 64'(last_rdata == 32'hA5A5A5A5), 64'd0);
        check("abort_kept", 64'(last_rdata), 64'(keep));

        idle_cycles(20);
        check("idle_rdata_held", 64'(rdata), 64'(last_rdata));

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                malformed_req();
            end else if (kind == 1) begin
                idle_cycles($urandom_range(1, 3));
            end else if (kind == 2) begin
                case ($urandom_range(0, 2))
                    0:       a = pool[$urandom_range(0, 7)] | 32'($urandom_range(1, 3));
                    1:       a = 32'(LIMIT) + 32'($urandom_range(0, 255) * 4);
                    default: a = 32'h8000_0000 | pool[$urandom_range(0, 7)];
                endcase
                access(1'($urandom_range(0, 1)), a, $urandom);
            end else begin
                access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom);
            end
        end

        // Zero-wait build: response one cycle after the request.
        access0(1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0);
        access0(1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
        access0(1'b0, 32'h2, 32'h0, 32'h0, 1'b1);

        idle_cycles(4);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side endpoint for the active-low memory controls (mem_enable, mem_read, mem_write) driven by the main control decoder.
- Accepts one word access at a time and inserts a configurable number of wait states.
- Returns read data with a one-cycle ready pulse.
- Drives a stall to the PC/pipeline so the single-cycle core freezes until the access completes.

Parameters:
- DEPTH_LOG2, 8, log2 of word count (256 x 32-bit words).
- WAIT_CYCLES, 2, wait states between request detect and response; 0 is legal.
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_enable  in  1  active-low access enable from control decoder.
- mem_read  in  1  active-low read strobe.
- mem_write  in  1  active-low write strobe.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  DATA_W  store data (rt register value).
- rdata  out  DATA_W  registered load data.
- ready  out  1  one-cycle response pulse.
- stall  out  1  freeze core; combinational.
- err  out  1  one-cycle error pulse.

Behaviour:
- Clocking: one clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising clk edge.
- Reset values: state=IDLE; rdata=0; ready=0; err=0; wait counter=0. Memory contents are not cleared; unwritten words read as X in simulation.
- Valid request (req): mem_enable==0 and exactly one of mem_read/mem_write==0.
- Malformed request: mem_enable==0 with both strobes low, or both strobes high.
  - err=1 for one cycle, no access, state stays IDLE, stall=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - stall = req (combinational).
  - On req, latch addr, wdata and op (read/write).
  - WAIT_CYCLES>0: go to WAIT, counter=WAIT_CYCLES-1.
  - WAIT_CYCLES==0: go to RESP.
- WAIT:
  - stall=1.
  - counter decrements each cycle.
  - On counter==0, go to RESP; the array access occurs on this transition edge.
  - WAIT occupies exactly WAIT_CYCLES cycles.
- Array access (on the edge into RESP):
  - Write: mem[latched_addr[DEPTH_LOG2+1:2]] <= latched_wdata.
  - Read: rdata <= mem[index].
- RESP:
  - ready=1, stall=0.
  - Unconditionally return to IDLE next cycle.
  - The core advances on this cycle, so the next cycle's request is a new instruction.
- Latency: request detected in cycle 0; ready asserted in cycle WAIT_CYCLES+1.
- Misaligned request (latched addr[1:0]!=0):
  - No write, rdata <= 0.
  - In RESP, err=1 together with ready=1.
- Out-of-range request (latched addr bits above DEPTH_LOG2+1 nonzero): same as misaligned (err, no write, rdata=0).
- rdata holds its value between reads; writes do not change rdata.
- Input changes while in WAIT are ignored; only the latched values are used.
- Reset mid-operation (rst in WAIT or RESP):
  - Return to IDLE with outputs at reset values.
  - A write whose commit edge coincides with rst is not committed (rst has priority).
- err and ready are never both asserted except in the misaligned/out-of-range RESP case.

Decomposition:
- Shared package (dmem_pkg):
  - state enum IDLE/WAIT/RESP (2-bit).
  - ACTIVE_LOW_ASSERT=1'b0 polarity constant, matching the control decoder's memory strobes.
  - default DEPTH_LOG2/WAIT_CYCLES.
- Sub-module dmem_array: single-port synchronous RAM (we, index, wdata -> registered rdata), parameterized by DEPTH_LOG2/DATA_W.
- The responder FSM, address check and counter stay in dmem_responder.

Test Plan:
- Store then load, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to addr 0x10: stall=1 in cycles 0-2, ready=1 in cycle 3.
  - Then read addr 0x10: rdata=0xDEADBEEF with ready in cycle 3.
- WAIT_CYCLES=0 build: read of a previously written 0x12345678 at addr 0x0 -> ready in cycle 1, stall only in cycle 0.
- Misaligned store to addr 0x13 with wdata 0xFFFFFFFF:
  - err=1 and ready=1 in the same cycle, rdata=0.
  - A subsequent read of 0x10 returns the prior value, proving no write occurred.
- Malformed control (mem_enable=0, mem_read=0, mem_write=0): err=1 for one cycle, stall=0, state remains IDLE, no array access.
- Reset mid-access: issue a write of 0xA5A5A5A5 to 0x20 and assert rst in cycle 2 (the commit edge):
  - ready never pulses; outputs at reset values.
  - A later read of 0x20 does not return 0xA5A5A5A5.
- Idle inputs (mem_enable=1, strobes arbitrary): stall=0, ready=0 and err=0 for 20 cycles; rdata unchanged.
